mux_arb_reg: RTL and testbench

- Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshake on every input and on the output.
- Generalises the 2:1 behavioural mux. Adds three selection modes (static select, fixed priority, round-robin), a one-deep output register and a transfer counter.
- Sits between several producer channels and a single consumer stage.

---
 rtl/mux_arb_reg.sv | 111 +++++++++++
 tb/tb_mux_arb_reg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
// N-input registered mux with static / fixed-priority / round-robin grant; 1-cycle latency, full throughput.
// Backpressure: while the output word is held (out_valid && !out_ready) every in_ready is low.
module mux_arb_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan,
  output logic [CNTW-1:0]      xfer_cnt
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_chan;
  logic [CNTW-1:0]  r_xfer_cnt;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_load;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_ch [N];

  function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return SELW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) w_ch[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign w_load = !r_out_valid || out_ready;

  // Loops run from the far end so the nearest candidate is written last and wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    case (mode)
      2'b01: begin
        for (int i = N-1; i >= 0; i--) begin
          if (in_valid[i]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = SELW'(i);
          end
        end
      end
      2'b10: begin
        for (int k = N-1; k >= 0; k--) begin
          if (in_valid[rr_idx(r_rr_ptr, k)]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = rr_idx(r_rr_ptr, k);
          end
        end
      end
      default: begin
        if (int'(sel) < N && in_valid[sel]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = sel;
        end
      end
    endcase
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++)
      in_ready[i] = rst_n && w_load && w_gnt_vld && (w_gnt_idx == SELW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_xfer_cnt  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (r_out_valid && out_ready) r_xfer_cnt <= r_xfer_cnt + CNTW'(1);
      if (w_load) begin
        if (w_gnt_vld) begin
          r_out_data  <= w_ch[w_gnt_idx];
          r_out_chan  <= w_gnt_idx;
          r_out_valid <= 1'b1;
          if (mode == 2'b10)
            r_rr_ptr <= (w_gnt_idx == SELW'(N-1)) ? '0 : w_gnt_idx + SELW'(1);
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mux_arb_reg;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;
  localparam int CNTW  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          mode;
  logic [SELW-1:0]     sel;
  logic [N*WIDTH-1:0]  in_data;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic [SELW-1:0]     out_chan;
  logic [CNTW-1:0]     xfer_cnt;
  logic [WIDTH-1:0]    ch [N];

  int n_vec = 0;
  int n_err = 0;

  // reference state
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_chan;
  logic [CNTW-1:0]  m_cnt;
  int               m_rr;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = ch[i];
  end

  mux_arb_reg #(.WIDTH(WIDTH), .N(N), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .xfer_cnt(xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Candidate list in search order for the current mode; first valid one wins.
  function automatic int ref_grant();
    int order[$];
    case (mode)
      2'b01:   for (int i = 0; i < N; i++) order.push_back(i);
      2'b10:   for (int k = 0; k < N; k++) order.push_back((m_rr + k) % N);
      default: if (int'(sel) < N) order.push_back(int'(sel));
    endcase
    foreach (order[q]) if (in_valid[order[q]]) return order[q];
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = ref_grant();
    if (!rst_n) return '0;
    if ((!m_valid || out_ready) && g >= 0) return N'(1) << g;
    return '0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_chan = 0; m_cnt = '0; m_rr = 0;
  endtask

  task automatic model_step();
    int g;
    bit load;
    g    = ref_grant();
    load = !m_valid || out_ready;
    if (m_valid && out_ready) m_cnt = m_cnt + 1'b1;
    if (load) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = ch[g];
        m_chan  = g;
        if (mode == 2'b10) m_rr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".rdy"},  32'(in_ready),  32'(exp_ready()));
    chk({pfx, ".vld"},  32'(out_valid), 32'(m_valid));
    chk({pfx, ".dat"},  32'(out_data),  32'(m_data));
    chk({pfx, ".chan"}, 32'(out_chan),  32'(m_chan));
    chk({pfx, ".cnt"},  32'(xfer_cnt),  32'(m_cnt));
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic cycle(input string pfx);
    #1;
    check_all(pfx);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst.rdy", 32'(in_ready), 32'h0);
    chk("rst.vld", 32'(out_valid), 32'h0);
    chk("rst.cnt", 32'(xfer_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_ch(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                        input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
    ch[0] = d0; ch[1] = d1; ch[2] = d2; ch[3] = d3;
  endtask

  initial begin
    logic [SELW-1:0] rr_seq [6];
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst_n = 1'b0; mode = 2'b01; sel = '0; in_valid = '1; out_ready = 1'b1;
    set_ch(8'h01, 8'h02, 8'h03, 8'h04);
    model_reset();
    do_reset();

    // static select
    mode = 2'b00; sel = 2'd2; in_valid = 4'b0100; set_ch(8'h00, 8'h00, 8'hA5, 8'h00);
    cycle("st");
    chk("st.vld1", 32'(out_valid), 32'h1);
    chk("st.dat1", 32'(out_data), 32'hA5);
    chk("st.chan1", 32'(out_chan), 32'h2);
    in_valid = 4'b0000;
    cycle("st2");
    chk("st.cnt1", 32'(xfer_cnt), 32'h1);

    // fixed priority
    mode = 2'b01; in_valid = 4'b1010; set_ch(8'h00, 8'h11, 8'h00, 8'h33);
    for (int c = 0; c < 3; c++) begin
      cycle("fp");
      chk("fp.dat", 32'(out_data), 32'h11);
    end
    in_valid = 4'b1000;
    cycle("fp3");
    chk("fp.dat3", 32'(out_data), 32'h33);
    chk("fp.chan3", 32'(out_chan), 32'h3);

    // round-robin from a fresh pointer
    do_reset();
    mode = 2'b10; in_valid = 4'b1111; set_ch(8'h10, 8'h11, 8'h12, 8'h13);
    for (int c = 0; c < 6; c++) begin
      cycle("rr");
      chk("rr.seq", 32'(out_chan), 32'(rr_seq[c]));
    end
    in_valid = 4'b0000;
    cycle("rr.drain");
    chk("rr.cnt6", 32'(xfer_cnt), 32'd6);

    // backpressure
    mode = 2'b00; sel = 2'd0; in_valid = 4'b0001; set_ch(8'h5A, 8'h00, 8'h00, 8'h00);
    cycle("bp.load");
    out_ready = 1'b0; ch[0] = 8'h77;
    for (int c = 0; c < 4; c++) begin
      cycle("bp.hold");
      chk("bp.dat", 32'(out_data), 32'h5A);
      chk("bp.cntheld", 32'(xfer_cnt), 32'd6);
    end
    out_ready = 1'b1;
    cycle("bp.rel");
    chk("bp.cnt", 32'(xfer_cnt), 32'd7);
    chk("bp.next", 32'(out_data), 32'h77);

    // static select of an idle channel
    sel = 2'd2; in_valid = 4'b1011;
    cycle("st.idle");
    chk("st.idle.vld", 32'(out_valid), 32'h0);
    cycle("st.idle2");

    // asynchronous reset mid-stream
    do_reset();
    mode = 2'b10; in_valid = 4'b1111; set_ch(8'h20, 8'h21, 8'h22, 8'h23);
    for (int c = 0; c < 3; c++) cycle("rr2");
    chk("rr2.chan", 32'(out_chan), 32'h2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.vld", 32'(out_valid), 32'h0);
    chk("arst.dat", 32'(out_data), 32'h0);
    chk("arst.cnt", 32'(xfer_cnt), 32'h0);
    chk("arst.rdy", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("arst.rel");
    chk("arst.first", 32'(out_chan), 32'h0);
    chk("arst.firstdat", 32'(out_data), 32'h20);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      sel       = SELW'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) ch[i] = WIDTH'($urandom);
      cycle("rnd");
    end
    #1 check_all("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
